// File: rtl/z80_ld_r_hl_exec.sv
// Executes the Z80 "LD r,(HL)" instruction: fetch opcode, decode, read (HL), write back r.
// Anything that is not LD r,(HL) (HALT included) retires at once, flagged illegal.
module z80_ld_r_hl_exec (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] pc_in,
  input  logic [15:0] hl,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        reg_wr,
  output logic [2:0]  reg_wnum,
  output logic [7:0]  reg_wdata,
  output logic        busy,
  output logic        done,
  output logic        illegal,
  output logic [7:0]  ret_insn,
  output logic [15:0] ret_mem_addr,
  output logic [7:0]  ret_mem_rdata,
  output logic [15:0] ret_pc_wdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_WB
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [7:0]  insn_q, insn_d;
  logic [15:0] hl_q, hl_d;
  logic [7:0]  data_q, data_d;

  logic        legal;
  logic [15:0] pc_inc;

  // LD r,(HL) is 01rrr110; rrr=110 would be 0x76 (HALT), which is not a load.
  assign legal  = (insn_q[7:6] == 2'b01) && (insn_q[2:0] == 3'b110) &&
                  (insn_q[5:3] != 3'b110);
  assign pc_inc = pc_q + 16'd1;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      insn_q  <= '0;
      hl_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      insn_q  <= insn_d;
      hl_q    <= hl_d;
      data_q  <= data_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    insn_d        = insn_q;
    hl_d          = hl_q;
    data_d        = data_q;
    mem_req       = 1'b0;
    mem_addr      = '0;
    reg_wr        = 1'b0;
    reg_wnum      = '0;
    reg_wdata     = '0;
    done          = 1'b0;
    illegal       = 1'b0;
    ret_insn      = '0;
    ret_mem_addr  = '0;
    ret_mem_rdata = '0;
    ret_pc_wdata  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d    = pc_in;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ack) begin
          insn_d  = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (legal) begin
          hl_d    = hl;
          state_d = S_READ;
        end else begin
          done         = 1'b1;
          illegal      = 1'b1;
          ret_insn     = insn_q;
          ret_pc_wdata = pc_inc;
          state_d      = S_IDLE;
        end
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = hl_q;
        if (mem_ack) begin
          data_d  = mem_rdata;
          state_d = S_WB;
        end
      end
      S_WB: begin
        reg_wr        = 1'b1;
        reg_wnum      = insn_q[5:3];
        reg_wdata     = data_q;
        done          = 1'b1;
        ret_insn      = insn_q;
        ret_mem_addr  = hl_q;
        ret_mem_rdata = data_q;
        ret_pc_wdata  = pc_inc;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_z80_ld_r_hl_exec.sv
// Directed, table-driven bench for z80_ld_r_hl_exec with a wait-state memory responder.
module tb_z80_ld_r_hl_exec;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pc_in = '0;
  logic [15:0] hl = '0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        reg_wr;
  logic [2:0]  reg_wnum;
  logic [7:0]  reg_wdata;
  logic        busy;
  logic        done;
  logic        illegal;
  logic [7:0]  ret_insn;
  logic [15:0] ret_mem_addr;
  logic [7:0]  ret_mem_rdata;
  logic [15:0] ret_pc_wdata;

  z80_ld_r_hl_exec dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .pc_in         (pc_in),
    .hl            (hl),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .reg_wr        (reg_wr),
    .reg_wnum      (reg_wnum),
    .reg_wdata     (reg_wdata),
    .busy          (busy),
    .done          (done),
    .illegal       (illegal),
    .ret_insn      (ret_insn),
    .ret_mem_addr  (ret_mem_addr),
    .ret_mem_rdata (ret_mem_rdata),
    .ret_pc_wdata  (ret_pc_wdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [15:0] hl;
    logic [7:0]  op;
    logic [7:0]  data;
    int          wf;        // wait cycles on the opcode fetch
    int          wr;        // wait cycles on the (HL) read
    bit          disturb;   // pulse start in FETCH and change hl in READ
    bit          ill;
    logic [2:0]  wnum;
    logic [15:0] pcw;
    int          done_cyc;  // start cycle is cycle 0
  } vec_t;

  vec_t vecs[7];

  task automatic run_vec(input vec_t v);
    int          cyc;
    int          acc;
    int          waitc;
    int          reads;
    bit          finished;
    bit          in_req;
    logic [15:0] addr0;
    @(posedge clk); #1;
    start = 1'b1; pc_in = v.pc; hl = v.hl;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; acc = 0; waitc = 0; reads = 0; finished = 0; in_req = 0; addr0 = '0;
    while (!finished && cyc < 60) begin
      mem_ack = 1'b0;
      mem_rdata = 8'h00;
      if (mem_req) begin
        if (!in_req) begin
          in_req = 1; addr0 = mem_addr; waitc = 0;
          if (acc == 0) check("fetch_addr", 32'(mem_addr), 32'(v.pc));
          else begin
            reads++;
            check("read_addr", 32'(mem_addr), 32'(v.hl));
          end
        end else begin
          check("addr_stable", 32'(mem_addr), 32'(addr0));
        end
        if (waitc == ((acc == 0) ? v.wf : v.wr)) begin
          mem_ack = 1'b1;
          mem_rdata = (acc == 0) ? v.op : v.data;
        end else begin
          waitc++;
        end
      end
      start = v.disturb && (cyc == 1);
      if (v.disturb && acc == 1 && mem_req) hl = 16'h1234;
      #4;
      if (done) begin
        finished = 1;
        check("done_cycle", 32'(cyc), 32'(v.done_cyc));
        check("illegal", 32'(illegal), 32'(v.ill));
        check("ret_insn", 32'(ret_insn), 32'(v.op));
        check("ret_mem_addr", 32'(ret_mem_addr), v.ill ? 32'h0 : 32'(v.hl));
        check("ret_mem_rdata", 32'(ret_mem_rdata), v.ill ? 32'h0 : 32'(v.data));
        check("ret_pc_wdata", 32'(ret_pc_wdata), 32'(v.pcw));
        check("reg_wr", 32'(reg_wr), v.ill ? 32'h0 : 32'h1);
        check("read_count", 32'(reads), v.ill ? 32'h0 : 32'h1);
        if (!v.ill) begin
          check("reg_wnum", 32'(reg_wnum), 32'(v.wnum));
          check("reg_wdata", 32'(reg_wdata), 32'(v.data));
        end
      end else if (reg_wr) begin
        check("reg_wr_without_done", 32'(reg_wr), 32'h0);
      end
      @(posedge clk); #1;
      if (mem_ack) begin
        check("req_drop_after_ack", 32'(mem_req), 32'h0);
        acc++;
        in_req = 0;
      end
      cyc++;
    end
    mem_ack = 1'b0;
    start = 1'b0;
    check("done_seen", 32'(finished), 32'h1);
    #4;
    check("no_double_done", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      check("idle_after_retire", {30'h0, busy, mem_req}, 32'h0);
      @(negedge clk);
    end
  endtask

  initial begin
    //          pc       hl       op     data   wf wr dist ill  wnum  pcw      done
    vecs[0] = '{16'h1000, 16'h2000, 8'h7E, 8'hA5, 0, 0, 1'b0, 1'b0, 3'd7, 16'h1001, 4};
    vecs[1] = '{16'h3000, 16'h4000, 8'h76, 8'hEE, 0, 0, 1'b0, 1'b1, 3'd0, 16'h3001, 2};
    vecs[2] = '{16'h0100, 16'hFFFF, 8'h46, 8'h3C, 3, 3, 1'b0, 1'b0, 3'd0, 16'h0101, 10};
    vecs[3] = '{16'hFFFF, 16'h0010, 8'h6E, 8'h5A, 0, 0, 1'b0, 1'b0, 3'd5, 16'h0000, 4};
    vecs[4] = '{16'h1234, 16'h5555, 8'h00, 8'h99, 1, 0, 1'b0, 1'b1, 3'd0, 16'h1235, 3};
    vecs[5] = '{16'h2222, 16'h8000, 8'h4E, 8'h11, 1, 2, 1'b1, 1'b0, 3'd1, 16'h2223, 7};
    vecs[6] = '{16'h4444, 16'h9000, 8'h7F, 8'h22, 0, 0, 1'b0, 1'b1, 3'd0, 16'h4445, 2};

    #2;
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_done_wr", {30'h0, done, reg_wr}, 32'h0);
    check("rst_ret_pc", 32'(ret_pc_wdata), 32'h0);
    #20 reset_n = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset while the (HL) read is pending, then a clean instruction.
    @(posedge clk); #1;
    start = 1'b1; pc_in = 16'h5000; hl = 16'h6000;
    @(posedge clk); #1;
    start = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h56;
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = 8'h00;
    @(posedge clk); #1;
    check("rst_read_req", 32'(mem_req), 32'h1);
    check("rst_read_addr", 32'(mem_addr), 32'h6000);
    #2 reset_n = 1'b0;
    #1;
    check("rst_async_req", 32'(mem_req), 32'h0);
    check("rst_async_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_no_retire", {30'h0, done, reg_wr}, 32'h0);
    end
    @(posedge clk); #3 reset_n = 1'b1;
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/z80_ld_r_hl_exec.md
Z80_LD_R_HL_EXEC -- requirements
Module: z80_ld_r_hl_exec

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; one clock domain only.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: start  in  1  begin one instruction at pc_in; sampled only in IDLE.
REQ-004 SHALL have: pc_in  in  16  address of the opcode byte.
REQ-005 SHALL have: hl  in  16  current HL register-file value.
REQ-006 SHALL have: mem_req  out  1  memory read request; held until mem_ack.
REQ-007 SHALL have: mem_addr  out  16  read address; stable while mem_req=1.
REQ-008 SHALL have: mem_ack  in  1  read complete; mem_rdata valid in the same cycle.
REQ-009 SHALL have: mem_rdata  in  8  read data.
REQ-010 SHALL have: reg_wr, reg_wnum, reg_wdata  out  1/3/8  register write: strobe, rrr code, data.
REQ-011 SHALL have: busy  out  1  high in every state except IDLE.
REQ-012 SHALL have: done, illegal  out  1/1  one-cycle retire pulse; illegal qualifies done.
REQ-013 SHALL have: ret_insn, ret_mem_addr, ret_mem_rdata, ret_pc_wdata  out  8/16/8/16  retirement record, valid when done=1.

Function
REQ-014 SHALL implement states IDLE, FETCH, DECODE, READ, WB.
REQ-015 IDLE: start=1 SHALL latch pc_in and go to FETCH on the next edge; start=0 SHALL keep IDLE.
REQ-016 FETCH: mem_req=1 and mem_addr=latched pc; mem_ack=1 SHALL latch mem_rdata as the opcode and go to DECODE; otherwise stay in FETCH.
REQ-017 DECODE: opcode matching 01rrr110 with rrr!=110 SHALL latch hl and go to READ.
REQ-018 DECODE: any other opcode, including 0x76, SHALL produce done=1 and illegal=1 in that cycle, skip READ and WB, and return to IDLE.
REQ-019 READ: mem_req=1 and mem_addr=latched HL; mem_ack=1 SHALL latch mem_rdata and go to WB.
REQ-020 WB: reg_wr=1, reg_wnum=rrr, reg_wdata=latched byte, done=1 and illegal=0 for exactly one cycle, then return to IDLE.
REQ-021 mem_req SHALL be 0 in IDLE, DECODE and WB, and SHALL deassert in the cycle after mem_ack is sampled.
REQ-022 Any number of wait cycles SHALL be tolerated: mem_req and mem_addr stay constant until mem_ack.
REQ-023 mem_ack in IDLE, DECODE or WB SHALL be ignored.
REQ-024 start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-025 ret_pc_wdata SHALL equal latched pc + 1, modulo 2^16 (0xFFFF gives 0x0000).
REQ-026 ret_mem_addr SHALL equal latched HL; for the illegal path it SHALL be 0x0000, and ret_mem_rdata SHALL be 0x00.
REQ-027 ret_insn SHALL equal the fetched opcode on both paths.
REQ-028 A change on hl after DECODE SHALL NOT affect mem_addr or the retirement record.
REQ-029 Minimum latency with mem_ack asserted the first cycle it is sampled SHALL be 4 cycles from start to done.
REQ-030 reg_wr SHALL be asserted only in WB; done SHALL never be asserted in two consecutive cycles.

Reset
REQ-031 reset_n=0 SHALL immediately force state IDLE, without waiting for a clock edge.
REQ-032 While reset_n=0, all outputs and latched fields SHALL read 0.
REQ-033 Reset mid-instruction SHALL abandon the instruction: no reg_wr and no done; mem_req drops asynchronously.
REQ-034 After reset_n rises, the first accepted start SHALL be sampled at the first rising edge with reset_n=1.

Verification
REQ-035 Read path: pc=0x1000, mem[0x1000]=0x7E, hl=0x2000, mem[0x2000]=0xA5, zero-wait memory -> READ addr 0x2000; WB reg_wnum=7, reg_wdata=0xA5; done at cycle 4; ret_pc_wdata=0x1001.
REQ-036 HALT opcode: opcode 0x76 -> done=1, illegal=1 in DECODE; no READ request; no reg_wr; ret_insn=0x76.
REQ-037 Wait states: 3 wait cycles on each access, opcode 0x46, hl=0xFFFF -> mem_addr stable throughout; reg_wnum=0; done at cycle 10.
REQ-038 PC wrap: pc_in=0xFFFF, opcode 0x6E -> ret_pc_wdata=0x0000; reg_wnum=5.
REQ-039 Reset during READ: assert reset_n=0 while mem_req=1 -> mem_req=0 at once; no done; next start executes normally.
REQ-040 Ignored inputs: start pulsed in FETCH, and hl changed to 0x1234 in READ -> no second instruction; mem_addr keeps the HL value latched in DECODE.
